// File: rtl/apb_requester_nslv_if.sv
// Request/APB signal bundle for apb_requester_nslv.
// The master modport is the requester's view; slave is the opposite side (front logic + completers).
interface apb_requester_nslv_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4
);
    // Front-side request port
    logic                          transfer;
    logic                          write;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          ready;
    logic                          error;

    // APB completer bus
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [NUM_SLV-1:0]            PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [NUM_SLV-1:0]            PREADY;
    logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLV-1:0]            PSLVERR;

    modport master (
        input  transfer, write, addr, wdata, PREADY, PRDATA, PSLVERR,
        output rdata, ready, error, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output transfer, write, addr, wdata, PREADY, PRDATA, PSLVERR,
        input  rdata, ready, error, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_requester_nslv.sv
// APB requester for NUM_SLV completers: decodes a slot field of the front address into a
// one-hot PSEL, runs SETUP/ACCESS, returns PSLVERR/decode-miss/timeout as error.
// Every output is registered; ready/error/rdata are single-cycle completion values.
module apb_requester_nslv #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int SLOT_LSB   = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_requester_nslv_if.master bus
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_nxt;
    logic [SEL_W-1:0]      slot_q, slot_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;

    logic [ADDR_WIDTH-1:0] paddr_q, paddr_nxt;
    logic                  pwrite_q, pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_nxt;
    logic [NUM_SLV-1:0]    psel_q, psel_nxt;
    logic                  penable_q, penable_nxt;
    logic                  ready_q, ready_nxt;
    logic                  error_q, error_nxt;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;

    logic [SEL_W-1:0]      req_slot;
    logic                  req_hit;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] slot_rdata;

    assign req_slot    = bus.addr[SLOT_LSB +: SEL_W];
    // A slot field wider than the completer count can name a completer that does not exist.
    assign req_hit     = (int'(req_slot) < NUM_SLV);
    // Last permitted wait state: with PREADY still low here the transfer is abandoned.
    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);
    assign slot_rdata  = bus.PRDATA[slot_q*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and next-output decode for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the case can infer a latch.
        state_nxt   = state_q;
        slot_nxt    = slot_q;
        cnt_nxt     = cnt_q;
        paddr_nxt   = paddr_q;
        pwrite_nxt  = pwrite_q;
        pwdata_nxt  = pwdata_q;
        psel_nxt    = psel_q;
        penable_nxt = penable_q;
        ready_nxt   = 1'b0;
        error_nxt   = 1'b0;
        rdata_nxt   = '0;

        case (state_q)
            IDLE: begin
                psel_nxt    = '0;
                penable_nxt = 1'b0;
                if (bus.transfer) begin
                    paddr_nxt  = bus.addr;
                    pwrite_nxt = bus.write;
                    pwdata_nxt = bus.wdata;
                    if (req_hit) begin
                        slot_nxt  = req_slot;
                        psel_nxt  = NUM_SLV'(1) << req_slot;
                        state_nxt = SETUP;
                    end else begin
                        // Decode miss: complete with error without touching the bus.
                        ready_nxt = 1'b1;
                        error_nxt = 1'b1;
                    end
                end
            end

            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = ACCESS;
            end

            ACCESS: begin
                // PREADY is checked before the timeout so a late completer still wins.
                if (bus.PREADY[slot_q]) begin
                    state_nxt   = IDLE;
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    ready_nxt   = 1'b1;
                    error_nxt   = bus.PSLVERR[slot_q];
                    if (!pwrite_q && !bus.PSLVERR[slot_q]) begin
                        rdata_nxt = slot_rdata;
                    end
                end else if (timeout_hit) begin
                    state_nxt   = IDLE;
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    ready_nxt   = 1'b1;
                    error_nxt   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                psel_nxt    = '0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Captured request, wait counter and registered bus/front outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            slot_q    <= '0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            slot_q    <= slot_nxt;
            cnt_q     <= cnt_nxt;
            paddr_q   <= paddr_nxt;
            pwrite_q  <= pwrite_nxt;
            pwdata_q  <= pwdata_nxt;
            psel_q    <= psel_nxt;
            penable_q <= penable_nxt;
            ready_q   <= ready_nxt;
            error_q   <= error_nxt;
            rdata_q   <= rdata_nxt;
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_apb_requester_nslv.sv
// Self-checking bench for apb_requester_nslv: directed scenarios plus randomized requests
// checked against a transaction-level model of latency, error and read data.
module tb_apb_requester_nslv;
    localparam int AW       = 32;
    localparam int DW       = 32;
    // Five completers: a 3-bit slot field can then name slots 5..7, which must miss.
    localparam int NS       = 5;
    localparam int SLOT_LSB = 12;
    localparam int TIMEOUT  = 16;
    localparam int SEL_W    = (NS > 1) ? $clog2(NS) : 1;
    localparam int MAXC     = TIMEOUT + 12;

    logic PCLK = 1'b0;
    logic PRESETn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    apb_requester_nslv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS)) bus ();

    apb_requester_nslv #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS), .SLOT_LSB(SLOT_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int              lat;
        logic            err;
        logic [DW-1:0]   rdata;
        bit              hit;
        logic [NS-1:0]   psel;
    } exp_t;

    // Observations from the most recent transaction, indexed by cycle after the request.
    int              obs_lat;
    logic            obs_err;
    logic [DW-1:0]   obs_rdata;
    logic [NS-1:0]   snap_psel   [MAXC+1];
    logic            snap_pen    [MAXC+1];
    logic [AW-1:0]   snap_paddr  [MAXC+1];
    logic            snap_pwrite [MAXC+1];
    logic [DW-1:0]   snap_pwdata [MAXC+1];

    // Transaction-level expectation: latency in cycles from request to ready, and the result.
    function automatic exp_t model(input logic [AW-1:0] a, input logic wr, input int w,
                                   input logic serr, input logic [DW-1:0] rd);
        exp_t          e;
        int            slot;
        logic [NS-1:0] one;
        one     = '0;
        one[0]  = 1'b1;
        slot    = int'((a >> SLOT_LSB) % (1 << SEL_W));
        e.hit   = (slot < NS);
        e.psel  = e.hit ? (one << slot) : '0;
        e.err   = 1'b1;
        e.rdata = '0;
        if (!e.hit) begin
            e.lat = 1;
        end else if (TIMEOUT > 0 && w >= TIMEOUT) begin
            e.lat = 2 + TIMEOUT;
        end else begin
            e.lat = 3 + w;
            e.err = serr;
            if (!wr && !serr) e.rdata = rd;
        end
        return e;
    endfunction

    // Issue one request in the current cycle and act as the completers until ready or budget.
    // w = ACCESS cycles with PREADY low before it rises; noise = random transfer while busy.
    task automatic run_txn(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                           input int w, input logic serr, input logic [DW-1:0] rd, input bit noise);
        int slot;
        int acc;
        slot = int'((a >> SLOT_LSB) % (1 << SEL_W));
        bus.transfer = 1'b1;
        bus.addr     = a;
        bus.write    = wr;
        bus.wdata    = wd;
        for (int i = 0; i < NS; i++) bus.PRDATA[i*DW +: DW] = DW'($urandom);
        bus.PREADY  = NS'($urandom);
        bus.PSLVERR = NS'($urandom);
        if (slot < NS) begin
            bus.PRDATA[slot*DW +: DW] = rd;
            bus.PREADY[slot]          = 1'b0;
            bus.PSLVERR[slot]         = serr;
        end
        acc       = 0;
        obs_lat   = 0;
        obs_err   = 1'b0;
        obs_rdata = '0;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge PCLK);
            snap_psel[c]   = bus.PSEL;
            snap_pen[c]    = bus.PENABLE;
            snap_paddr[c]  = bus.PADDR;
            snap_pwrite[c] = bus.PWRITE;
            snap_pwdata[c] = bus.PWDATA;
            if (bus.ready) begin
                obs_lat      = c;
                obs_err      = bus.error;
                obs_rdata    = bus.rdata;
                bus.transfer = 1'b0;
                break;
            end
            bus.transfer = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                bus.addr  = AW'($urandom);
                bus.write = 1'($urandom);
                bus.wdata = DW'($urandom);
            end
            bus.PREADY  = NS'($urandom);
            bus.PSLVERR = NS'($urandom);
            if (slot < NS) begin
                if (bus.PSEL[slot] && bus.PENABLE) acc++;
                bus.PREADY[slot]  = (acc == w + 1);
                bus.PSLVERR[slot] = serr;
            end
        end
        bus.transfer = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn      = 1'b0;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.PREADY   = '0;
        bus.PRDATA   = '0;
        bus.PSLVERR  = '0;
        repeat (3) @(negedge PCLK);
        tests_run++;
        if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_bus: PSEL=%0h PENABLE=%0h, required 0 0", bus.PSEL, bus.PENABLE);
        end
        tests_run++;
        if (bus.ready !== 1'b0 || bus.error !== 1'b0 || bus.rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_front: ready=%0h error=%0h rdata=%0h, required 0 0 0",
                     bus.ready, bus.error, bus.rdata);
        end
        tests_run++;
        if (bus.PADDR !== '0 || bus.PWRITE !== 1'b0 || bus.PWDATA !== '0) begin
            tests_failed++;
            $display("FAIL reset_capture: PADDR=%0h PWRITE=%0h PWDATA=%0h, required 0 0 0",
                     bus.PADDR, bus.PWRITE, bus.PWDATA);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_write();
        run_txn(32'h0000_2010, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (obs_lat !== 3 || obs_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_done: ready at %0d error=%0h, required 3 0", obs_lat, obs_err);
        end
        tests_run++;
        if (snap_psel[1] !== 5'b00100 || snap_psel[2] !== 5'b00100 || snap_psel[3] !== 5'b00000) begin
            tests_failed++;
            $display("FAIL write_psel: %0h %0h %0h, required 4 4 0", snap_psel[1], snap_psel[2], snap_psel[3]);
        end
        tests_run++;
        if (snap_pen[1] !== 1'b0 || snap_pen[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_penable: %0h %0h, required 0 1", snap_pen[1], snap_pen[2]);
        end
        tests_run++;
        if (snap_paddr[1] !== 32'h0000_2010 || snap_pwrite[1] !== 1'b1 || snap_pwdata[2] !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL write_fields: PADDR=%0h PWRITE=%0h PWDATA=%0h, required 2010 1 a5a50001",
                     snap_paddr[1], snap_pwrite[1], snap_pwdata[2]);
        end
        @(negedge PCLK);
        tests_run++;
        if (bus.ready !== 1'b0 || bus.error !== 1'b0 || bus.rdata !== '0 || bus.PSEL !== '0) begin
            tests_failed++;
            $display("FAIL write_pulse: ready=%0h error=%0h rdata=%0h PSEL=%0h, required all 0",
                     bus.ready, bus.error, bus.rdata, bus.PSEL);
        end
        tests_run++;
        if (bus.PADDR !== 32'h0000_2010 || bus.PWDATA !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL idle_hold: PADDR=%0h PWDATA=%0h, required 2010 a5a50001", bus.PADDR, bus.PWDATA);
        end
    endtask

    task automatic test_read_wait();
        run_txn(32'h0000_1000, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
        tests_run++;
        if (obs_lat !== 6 || obs_err !== 1'b0 || obs_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL read_wait: ready at %0d error=%0h rdata=%0h, required 6 0 12345678",
                     obs_lat, obs_err, obs_rdata);
        end
        tests_run++;
        if (snap_pen[5] !== 1'b1 || snap_psel[5] !== 5'b00010) begin
            tests_failed++;
            $display("FAIL read_wait_access: PENABLE=%0h PSEL=%0h at cycle 5, required 1 2", snap_pen[5], snap_psel[5]);
        end
        @(negedge PCLK);
    endtask

    task automatic test_slverr();
        run_txn(32'h0000_3000, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tests_run++;
        if (obs_lat !== 5 || obs_err !== 1'b1 || obs_rdata !== '0) begin
            tests_failed++;
            $display("FAIL slverr: ready at %0d error=%0h rdata=%0h, required 5 1 0", obs_lat, obs_err, obs_rdata);
        end
        @(negedge PCLK);
    endtask

    task automatic test_decode_miss();
        run_txn(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== '0 || snap_psel[1] !== '0) begin
            tests_failed++;
            $display("FAIL decode_miss: ready at %0d error=%0h rdata=%0h PSEL=%0h, required 1 1 0 0",
                     obs_lat, obs_err, obs_rdata, snap_psel[1]);
        end
        @(negedge PCLK);
        tests_run++;
        if (bus.ready !== 1'b0 || bus.error !== 1'b0 || bus.PSEL !== '0) begin
            tests_failed++;
            $display("FAIL decode_miss_pulse: ready=%0h error=%0h PSEL=%0h, required 0 0 0",
                     bus.ready, bus.error, bus.PSEL);
        end
    endtask

    task automatic test_timeout();
        run_txn(32'h0000_0040, 1'b0, 32'h0, TIMEOUT, 1'b0, 32'h5555_AAAA, 1'b0);
        tests_run++;
        if (obs_lat !== 2 + TIMEOUT || obs_err !== 1'b1 || obs_rdata !== '0) begin
            tests_failed++;
            $display("FAIL timeout_abort: ready at %0d error=%0h rdata=%0h, required %0d 1 0",
                     obs_lat, obs_err, obs_rdata, 2 + TIMEOUT);
        end
        @(negedge PCLK);
        run_txn(32'h0000_0040, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 1'b0);
        tests_run++;
        if (obs_lat !== 2 + TIMEOUT || obs_err !== 1'b0 || obs_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL timeout_last_ready: ready at %0d error=%0h rdata=%0h, required %0d 0 cafef00d",
                     obs_lat, obs_err, obs_rdata, 2 + TIMEOUT);
        end
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back();
        int   lat_a;
        logic err_a;
        run_txn(32'h0000_0100, 1'b1, 32'h0BAD_CAFE, 1, 1'b0, 32'h0, 1'b0);
        lat_a = obs_lat;
        err_a = obs_err;
        // Second request is presented in the ready cycle of the first.
        run_txn(32'h0000_4008, 1'b0, 32'h0, 0, 1'b0, 32'h7777_0004, 1'b0);
        tests_run++;
        if (lat_a !== 4 || err_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: ready at %0d error=%0h, required 4 0", lat_a, err_a);
        end
        tests_run++;
        if (snap_psel[1] !== 5'b10000 || snap_pen[1] !== 1'b0 || snap_paddr[1] !== 32'h0000_4008) begin
            tests_failed++;
            $display("FAIL b2b_setup: PSEL=%0h PENABLE=%0h PADDR=%0h, required 10 0 4008",
                     snap_psel[1], snap_pen[1], snap_paddr[1]);
        end
        tests_run++;
        if (obs_lat !== 3 || obs_rdata !== 32'h7777_0004) begin
            tests_failed++;
            $display("FAIL b2b_second: ready at %0d rdata=%0h, required 3 77770004", obs_lat, obs_rdata);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid_access();
        bit saw_ready;
        bus.transfer    = 1'b1;
        bus.addr        = 32'h0000_3004;
        bus.write       = 1'b1;
        bus.wdata       = 32'h1111_2222;
        bus.PREADY      = '0;
        bus.PSLVERR     = '0;
        @(negedge PCLK);
        bus.transfer = 1'b0;
        @(negedge PCLK);
        tests_run++;
        if (bus.PENABLE !== 1'b1 || bus.PSEL !== 5'b01000) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: PENABLE=%0h PSEL=%0h, required 1 8", bus.PENABLE, bus.PSEL);
        end
        #2 PRESETn = 1'b0;
        #1;
        tests_run++;
        if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_drop: PSEL=%0h PENABLE=%0h ready=%0h, required 0 0 0",
                     bus.PSEL, bus.PENABLE, bus.ready);
        end
        bus.PREADY = '1;
        @(negedge PCLK);
        PRESETn   = 1'b1;
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            if (bus.ready || bus.PSEL != '0) saw_ready = 1'b1;
        end
        tests_run++;
        if (saw_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_ready: activity after aborted request=%0h, required 0", saw_ready);
        end
        run_txn(32'h0000_2000, 1'b0, 32'h0, 0, 1'b0, 32'h0000_ABCD, 1'b0);
        tests_run++;
        if (obs_lat !== 3 || obs_rdata !== 32'h0000_ABCD) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: ready at %0d rdata=%0h, required 3 abcd", obs_lat, obs_rdata);
        end
        @(negedge PCLK);
    endtask

    task automatic test_random();
        exp_t          e;
        logic [AW-1:0] a;
        logic          wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          serr;
        int            w;
        int            bad;
        for (int n = 0; n < 60; n++) begin
            a    = AW'($urandom);
            wr   = 1'($urandom);
            wd   = DW'($urandom);
            rd   = DW'($urandom);
            serr = ($urandom_range(0, 3) == 0);
            w    = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                               : $urandom_range(0, 4);
            e = model(a, wr, w, serr, rd);
            run_txn(a, wr, wd, w, serr, rd, 1'($urandom));
            tests_run++;
            if (obs_lat !== e.lat) begin
                tests_failed++;
                $display("FAIL rand_latency[%0d]: addr=%0h ready at %0d, required %0d", n, a, obs_lat, e.lat);
            end else begin
                tests_run++;
                if (obs_err !== e.err || obs_rdata !== e.rdata) begin
                    tests_failed++;
                    $display("FAIL rand_result[%0d]: error=%0h rdata=%0h, required %0h %0h",
                             n, obs_err, obs_rdata, e.err, e.rdata);
                end
                bad = 0;
                for (int c = 1; c <= e.lat; c++) begin
                    if (snap_psel[c] !== ((c < e.lat) ? e.psel : '0)) bad++;
                    if (snap_pen[c] !== (e.hit && c >= 2 && c < e.lat)) bad++;
                    if (e.hit && c < e.lat &&
                        (snap_paddr[c] !== a || snap_pwrite[c] !== wr || snap_pwdata[c] !== wd)) bad++;
                end
                tests_run++;
                if (bad != 0) begin
                    tests_failed++;
                    $display("FAIL rand_bus[%0d]: addr=%0h %0d bad bus cycles, required 0", n, a, bad);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge PCLK);
                tests_run++;
                if (bus.ready !== 1'b0 || bus.error !== 1'b0 || bus.rdata !== '0) begin
                    tests_failed++;
                    $display("FAIL rand_pulse[%0d]: ready=%0h error=%0h rdata=%0h, required 0 0 0",
                             n, bus.ready, bus.error, bus.rdata);
                end
            end
        end
        @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_decode_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
